// File: rtl/nvram_ctrl_if.sv
// CPU bus, host backup port and status bundle for nvram_ctrl.
// With NVRAM_CSUM_EN defined the bundle also carries host_csum.
interface nvram_ctrl_if #(
   parameter int AW = 8,
   parameter int DW = 4
) ();
   logic          cpu_cs;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_din;
   logic [DW-1:0] cpu_dout;
   logic          cpu_rvalid;
   logic          host_dump_req;
   logic          host_load_req;
   logic [DW-1:0] host_dout;
   logic [AW-1:0] host_dout_addr;
   logic          host_dout_valid;
   logic          host_dout_ready;
   logic [DW-1:0] host_din;
   logic          host_din_valid;
   logic          host_din_ready;
   logic          busy;
   logic          done;
   logic          dirty;
`ifdef NVRAM_CSUM_EN
   logic [7:0]    host_csum;
`endif

   modport master (
      output cpu_cs, cpu_we, cpu_addr, cpu_din,
      output host_dump_req, host_load_req, host_dout_ready, host_din, host_din_valid,
      input  cpu_dout, cpu_rvalid, host_dout, host_dout_addr, host_dout_valid,
      input  host_din_ready, busy, done, dirty
`ifdef NVRAM_CSUM_EN
      , input host_csum
`endif
   );

   modport slave (
      input  cpu_cs, cpu_we, cpu_addr, cpu_din,
      input  host_dump_req, host_load_req, host_dout_ready, host_din, host_din_valid,
      output cpu_dout, cpu_rvalid, host_dout, host_dout_addr, host_dout_valid,
      output host_din_ready, busy, done, dirty
`ifdef NVRAM_CSUM_EN
      , output host_csum
`endif
   );
endinterface

// File: rtl/nvram_ctrl.sv
// Arbiter/sequencer sharing one NVRAM port between the CPU and a host dump/load engine.
// Optional NVRAM_CSUM_EN adds a mod-256 nibble checksum of the last dump or load.
module nvram_ctrl #(
   parameter int AW = 8,
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          reset,
   nvram_ctrl_if.slave   bus,
   output logic [AW-1:0] nv_a,
   output logic [DW-1:0] nv_i,
   input  logic [DW-1:0] nv_o,
   output logic          nv_ce_n,
   output logic          nv_rw_n
);

   typedef enum logic [2:0] {IDLE, DUMP_RD, DUMP_OUT, LOAD, FIN} state_t;

   localparam logic [AW-1:0] ADDR_MAX = '1;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] addr;
   logic [AW-1:0] addr_next;
   logic          rd_pend;
   logic [DW-1:0] rd_hold;
   logic          first_out;
   logic [DW-1:0] dump_hold;
   logic          dirty_q;
   logic          cpu_wr;
   logic          cpu_rd;
   logic          op_start;
   logic          load_wr;
   logic          dump_acc;

   assign cpu_wr = bus.cpu_cs & bus.cpu_we;
   assign cpu_rd = bus.cpu_cs & ~bus.cpu_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Host sequencing; the CPU override at the end gives it the RAM port unconditionally.
   always_comb begin
      state_next         = state;
      addr_next          = addr;
      op_start           = 1'b0;
      load_wr            = 1'b0;
      dump_acc           = 1'b0;
      nv_ce_n            = 1'b1;
      nv_rw_n            = 1'b1;
      nv_a               = '0;
      nv_i               = '0;
      bus.host_din_ready = 1'b0;
      case (state)
         IDLE: begin
            if (bus.host_dump_req) begin
               state_next = DUMP_RD;
               addr_next  = '0;
               op_start   = 1'b1;
            end else if (bus.host_load_req) begin
               state_next = LOAD;
               addr_next  = '0;
               op_start   = 1'b1;
            end
         end
         DUMP_RD: begin
            if (!bus.cpu_cs) begin
               nv_ce_n    = 1'b0;
               nv_a       = addr;
               state_next = DUMP_OUT;
            end
         end
         DUMP_OUT: begin
            if (bus.host_dout_ready) begin
               dump_acc = 1'b1;
               if (addr == ADDR_MAX) begin
                  state_next = FIN;
               end else begin
                  addr_next  = addr + 1'b1;
                  state_next = DUMP_RD;
               end
            end
         end
         LOAD: begin
            bus.host_din_ready = ~bus.cpu_cs;
            if (bus.host_din_valid && !bus.cpu_cs) begin
               load_wr = 1'b1;
               nv_ce_n = 1'b0;
               nv_rw_n = 1'b0;
               nv_a    = addr;
               nv_i    = bus.host_din;
               if (addr == ADDR_MAX) state_next = FIN;
               else                  addr_next  = addr + 1'b1;
            end
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (bus.cpu_cs) begin
         nv_ce_n = 1'b0;
         nv_rw_n = ~bus.cpu_we;
         nv_a    = bus.cpu_addr;
         nv_i    = bus.cpu_we ? bus.cpu_din : '0;
      end
   end

   // nv_o is live only in the cycle after a read, so hold registers keep outputs stable afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr      <= '0;
         rd_pend   <= 1'b0;
         rd_hold   <= '0;
         first_out <= 1'b0;
         dump_hold <= '0;
         dirty_q   <= 1'b0;
      end else begin
         addr      <= addr_next;
         rd_pend   <= cpu_rd;
         first_out <= (state == DUMP_RD) && !bus.cpu_cs;
         if (rd_pend)   rd_hold   <= nv_o;
         if (first_out) dump_hold <= nv_o;
         if (cpu_wr)             dirty_q <= 1'b1;
         else if (state == FIN)  dirty_q <= 1'b0;
      end
   end

   assign bus.cpu_rvalid      = rd_pend;
   assign bus.cpu_dout        = rd_pend ? nv_o : rd_hold;
   assign bus.host_dout       = first_out ? nv_o : dump_hold;
   assign bus.host_dout_addr  = addr;
   assign bus.host_dout_valid = (state == DUMP_OUT);
   assign bus.busy            = (state != IDLE);
   assign bus.done            = (state == FIN);
   assign bus.dirty           = dirty_q;

`ifdef NVRAM_CSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         csum <= '0;
      else if (op_start) csum <= '0;
      else if (dump_acc) csum <= csum + 8'(bus.host_dout);
      else if (load_wr)  csum <= csum + 8'(bus.host_din);
   end

   assign bus.host_csum = csum;
`else
   logic unused_csum;
   assign unused_csum = op_start | load_wr | dump_acc;
`endif

endmodule
